// File: rtl/cascade_pkg.sv
// Shared constants and types for the classifier-stage weight fetch path.
package cascade_pkg;

    localparam int W_ADDR_DEF         = 12;
    localparam int W_DATA_DEF         = 3;
    localparam int RECTS_PER_FEAT_DEF = 3;
    localparam int W_FEAT_DEF         = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } fetch_state_t;

    typedef logic [RECTS_PER_FEAT_DEF*W_DATA_DEF-1:0] weight_word_t;

endpackage

// File: rtl/weights_fetch_ctrl.sv
// Walks the weights ROM for one stage, packs RECTS_PER_FEAT rect weights per feature
// and offers each packed word downstream over valid/ready.
module weights_fetch_ctrl
    import cascade_pkg::*;
#(
    parameter int W_ADDR         = W_ADDR_DEF,
    parameter int W_DATA         = W_DATA_DEF,
    parameter int RECTS_PER_FEAT = RECTS_PER_FEAT_DEF,
    parameter int W_FEAT         = W_FEAT_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [W_ADDR-1:0]                base_addr,
    input  logic [W_FEAT-1:0]                feat_count,
    input  logic                             abort,
    output logic                             rom_en,
    output logic [W_ADDR-1:0]                rom_addr,
    input  logic [W_DATA-1:0]                rom_data,
    output logic [RECTS_PER_FEAT*W_DATA-1:0] w_data,
    output logic                             w_valid,
    output logic                             w_last,
    input  logic                             w_ready,
    output logic                             busy,
    output logic                             done
);

    localparam int W_RECT = (RECTS_PER_FEAT > 1) ? $clog2(RECTS_PER_FEAT) : 1;
    localparam int W_WORD = RECTS_PER_FEAT * W_DATA;

    fetch_state_t       state_r, state_s;
    logic [W_FEAT-1:0]  feat_idx_r, feat_idx_s;
    logic [W_FEAT-1:0]  count_r, count_s;
    logic [W_RECT-1:0]  rect_idx_r, rect_idx_s;
    logic [W_ADDR-1:0]  base_r, base_s;
    logic [W_ADDR-1:0]  rom_addr_r, rom_addr_s;
    logic               rd_pend_r;
    logic [W_RECT-1:0]  rd_slot_r;
    logic               rom_en_r, w_valid_r, w_last_r, busy_r, done_r;
    logic [W_WORD-1:0]  w_data_r;
    logic               accept_s, last_s, last_next_s;

    // Address arithmetic wraps at W_ADDR bits, including the feature offset product.
    function automatic logic [W_ADDR-1:0] rect_addr(input logic [W_ADDR-1:0] base,
                                                    input logic [W_FEAT-1:0] feat,
                                                    input logic [W_RECT-1:0] rect);
        logic [W_ADDR-1:0] feat_a;
        feat_a = W_ADDR'(feat);
        return base + feat_a * W_ADDR'(RECTS_PER_FEAT) + W_ADDR'(rect);
    endfunction

    // Next-state, counter and address selection.
    always_comb begin
        state_s     = state_r;
        feat_idx_s  = feat_idx_r;
        rect_idx_s  = rect_idx_r;
        base_s      = base_r;
        count_s     = count_r;
        rom_addr_s  = rom_addr_r;
        accept_s    = w_valid_r && w_ready;
        last_s      = (feat_idx_r == count_r - W_FEAT'(1));
        if (abort && (state_r != IDLE)) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (feat_count != '0) begin
                            base_s     = base_addr;
                            count_s    = feat_count;
                            feat_idx_s = '0;
                            rect_idx_s = '0;
                            rom_addr_s = base_addr;
                            state_s    = FETCH;
                        end else begin
                            state_s = DONE;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                FETCH: begin
                    if (rect_idx_r == W_RECT'(RECTS_PER_FEAT - 1)) begin
                        state_s = WAIT;
                    end else begin
                        rect_idx_s = rect_idx_r + W_RECT'(1);
                        rom_addr_s = rect_addr(base_r, feat_idx_r, rect_idx_r + W_RECT'(1));
                    end
                end
                WAIT: begin
                    state_s = HOLD;
                end
                HOLD: begin
                    if (accept_s) begin
                        if (last_s) begin
                            state_s = DONE;
                        end else begin
                            feat_idx_s = feat_idx_r + W_FEAT'(1);
                            rect_idx_s = '0;
                            rom_addr_s = rect_addr(base_r, feat_idx_r + W_FEAT'(1), '0);
                            state_s    = FETCH;
                        end
                    end else begin
                        state_s = HOLD;
                    end
                end
                DONE: begin
                    state_s = IDLE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
        last_next_s = (feat_idx_s == count_s - W_FEAT'(1));
    end

    // State, counters and registered outputs, all derived from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            feat_idx_r <= '0;
            count_r    <= '0;
            rect_idx_r <= '0;
            base_r     <= '0;
            rom_addr_r <= '0;
            rom_en_r   <= 1'b0;
            w_valid_r  <= 1'b0;
            w_last_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            rd_pend_r  <= 1'b0;
            rd_slot_r  <= '0;
        end else begin
            state_r    <= state_s;
            feat_idx_r <= feat_idx_s;
            count_r    <= count_s;
            rect_idx_r <= rect_idx_s;
            base_r     <= base_s;
            rom_addr_r <= rom_addr_s;
            rom_en_r   <= (state_s == FETCH);
            w_valid_r  <= (state_s == HOLD);
            w_last_r   <= (state_s == HOLD) && last_next_s;
            busy_r     <= (state_s != IDLE);
            done_r     <= (state_s == DONE);
            // A read issued this cycle returns next cycle; drop it if we are cancelling.
            rd_pend_r  <= rom_en_r && (state_s != IDLE);
            rd_slot_r  <= rect_idx_r;
        end
    end

    // Capture returning ROM data into the slot of the rect that requested it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_data_r <= '0;
        end else if (rd_pend_r) begin
            for (int r = 0; r < RECTS_PER_FEAT; r++) begin
                if (rd_slot_r == W_RECT'(r)) begin
                    w_data_r[r*W_DATA +: W_DATA] <= rom_data;
                end
            end
        end else begin
            w_data_r <= w_data_r;
        end
    end

    assign rom_en   = rom_en_r;
    assign rom_addr = rom_addr_r;
    assign w_data   = w_data_r;
    assign w_valid  = w_valid_r;
    assign w_last   = w_last_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule
